// File: rtl/ecc_log_pkg.sv
// Shared types and helpers for the ECC error logger: event classes, the stored
// record layout, window FSM states and a saturating counter increment.
package ecc_log_pkg;

    localparam int ADDR_W_MAX = 32;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        CE   = 2'b01,
        UE   = 2'b10,
        AE   = 2'b11
    } err_type_t;

    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr;
        err_type_t             err_type;
        logic [7:0]            syndrome;
        logic                  injected;
    } err_record_t;

    typedef enum logic {
        WIN_IDLE,
        WIN_ARMED
    } win_state_t;

    // Counters up to 32 bits wide hold at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/ecc_log_if.sv
// Valid/ready record stream from the logger (master) to the software drain (slave).
interface ecc_log_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  log_valid;
    logic                  log_ready;
    logic [ADDR_WIDTH-1:0] log_addr;
    logic [1:0]            log_type;
    logic [7:0]            log_syndrome;
    logic                  log_injected;

    modport master (
        output log_valid, log_addr, log_type, log_syndrome, log_injected,
        input  log_ready
    );

    modport slave (
        input  log_valid, log_addr, log_type, log_syndrome, log_injected,
        output log_ready
    );
endinterface

// File: rtl/ecc_log_fifo.sv
// Synchronous record FIFO with flush; a push into a full FIFO is only taken
// when a pop frees the head slot in the same cycle.
module ecc_log_fifo
    import ecc_log_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  err_record_t wr_data,
    output err_record_t rd_data,
    output logic        full,
    output logic        empty
);
    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W:0] ptr_t;

    err_record_t mem [DEPTH];
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: the storage is reset so the head reads all-zero out of reset; at this depth it is cheap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!flush && do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= wr_data;
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

endmodule

// File: rtl/ecc_error_logger.sv
// Logs ECC checker events into a record FIFO, keeps saturating per-class counters,
// matches detections against injection pulses and raises a sticky interrupt.
module ecc_error_logger
    import ecc_log_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int LOG_DEPTH   = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int MISS_WINDOW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  err_valid,
    input  logic [1:0]            err_type,
    input  logic [ADDR_WIDTH-1:0] err_addr,
    input  logic [7:0]            err_syndrome,
    input  logic                  inject_pulse,
    input  logic                  log_clear,
    input  logic [CNT_WIDTH-1:0]  irq_threshold,
    input  logic                  irq_clear,
    ecc_log_if.master             log,
    output logic [CNT_WIDTH-1:0]  ce_count,
    output logic [CNT_WIDTH-1:0]  ue_count,
    output logic [CNT_WIDTH-1:0]  ae_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic                  overflow_flag,
    output logic                  irq
);
    localparam int WIN_W = $clog2(MISS_WINDOW + 1);

    function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] value);
        return CNT_WIDTH'(sat_inc(32'(value), CNT_WIDTH));
    endfunction

    err_type_t            ev_type;
    logic                 accept;
    logic                 pop;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    err_record_t          rec_in;
    err_record_t          head;
    logic [CNT_WIDTH-1:0] ce_next;
    logic                 irq_set;

    win_state_t           state, state_next;
    logic [WIN_W-1:0]     win_cnt, win_cnt_next;
    logic                 match;
    logic                 miss;

    assign ev_type = err_type_t'(err_type);
    assign accept  = err_valid && (ev_type != NONE) && !log_clear;
    assign pop     = !fifo_empty && log.log_ready && !log_clear;
    assign drop    = accept && fifo_full && !pop;
    assign ce_next = bump(ce_count);

    assign irq_set = (accept && (ev_type == UE || ev_type == AE)) || drop ||
                     (accept && ev_type == CE && irq_threshold != '0 && ce_next == irq_threshold);

    always_comb begin
        rec_in          = '0;
        rec_in.addr     = ADDR_W_MAX'(err_addr);
        rec_in.err_type = ev_type;
        rec_in.syndrome = err_syndrome;
        rec_in.injected = match;
    end

    ecc_log_fifo #(.DEPTH(LOG_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (log_clear),
        .push    (accept),
        .pop     (pop),
        .wr_data (rec_in),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign log.log_valid    = !fifo_empty;
    assign log.log_addr     = head.addr[ADDR_WIDTH-1:0];
    assign log.log_type     = head.err_type;
    assign log.log_syndrome = head.syndrome;
    assign log.log_injected = head.injected;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WIN_IDLE;
            win_cnt <= '0;
        end else begin
            state   <= state_next;
            win_cnt <= win_cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        win_cnt_next = win_cnt;
        match        = 1'b0;
        miss         = 1'b0;
        if (log_clear) begin
            state_next   = WIN_IDLE;
            win_cnt_next = '0;
        end else begin
            case (state)
                WIN_IDLE: begin
                    if (inject_pulse) begin
                        state_next   = WIN_ARMED;
                        win_cnt_next = WIN_W'(MISS_WINDOW);
                    end
                end
                WIN_ARMED: begin
                    if (accept) begin
                        match = 1'b1;
                        if (inject_pulse) win_cnt_next = WIN_W'(MISS_WINDOW);
                        else              state_next   = WIN_IDLE;
                    end else if (inject_pulse) begin
                        // The earlier injection escaped; the new one takes over the window.
                        miss         = 1'b1;
                        win_cnt_next = WIN_W'(MISS_WINDOW);
                    end else if (win_cnt == '0) begin
                        miss       = 1'b1;
                        state_next = WIN_IDLE;
                    end else begin
                        win_cnt_next = win_cnt - WIN_W'(1);
                    end
                end
                default: state_next = WIN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_count      <= '0;
            ue_count      <= '0;
            ae_count      <= '0;
            drop_count    <= '0;
            miss_count    <= '0;
            overflow_flag <= 1'b0;
            irq           <= 1'b0;
        end else if (log_clear) begin
            ce_count      <= '0;
            ue_count      <= '0;
            ae_count      <= '0;
            drop_count    <= '0;
            miss_count    <= '0;
            overflow_flag <= 1'b0;
            irq           <= 1'b0;
        end else begin
            if (accept && ev_type == CE) ce_count <= ce_next;
            if (accept && ev_type == UE) ue_count <= bump(ue_count);
            if (accept && ev_type == AE) ae_count <= bump(ae_count);
            if (drop)                    drop_count <= bump(drop_count);
            if (miss)                    miss_count <= bump(miss_count);
            // Set beats clear when both land in the same cycle.
            if (drop)           overflow_flag <= 1'b1;
            else if (irq_clear) overflow_flag <= 1'b0;
            if (irq_set)        irq <= 1'b1;
            else if (irq_clear) irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ecc_error_logger.sv
// Randomised and directed bench for ecc_error_logger against a queue-based
// model that tracks injection windows by absolute cycle deadlines.
module tb_ecc_error_logger;
    localparam int DEPTH = 8;
    localparam int MW    = 16;
    localparam int CMAX  = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_valid = 1'b0;
    logic [1:0]  err_type = 2'b00;
    logic [31:0] err_addr = '0;
    logic [7:0]  err_syndrome = '0;
    logic        inject_pulse = 1'b0;
    logic        log_clear = 1'b0;
    logic [15:0] irq_threshold = '0;
    logic        irq_clear = 1'b0;
    logic [15:0] ce_count, ue_count, ae_count, drop_count, miss_count;
    logic        overflow_flag, irq;

    ecc_log_if #(.ADDR_WIDTH(32)) intf ();

    ecc_error_logger #(
        .ADDR_WIDTH(32), .LOG_DEPTH(DEPTH), .CNT_WIDTH(16), .MISS_WINDOW(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .err_valid(err_valid), .err_type(err_type),
        .err_addr(err_addr), .err_syndrome(err_syndrome), .inject_pulse(inject_pulse),
        .log_clear(log_clear), .irq_threshold(irq_threshold), .irq_clear(irq_clear),
        .log(intf), .ce_count(ce_count), .ue_count(ue_count), .ae_count(ae_count),
        .drop_count(drop_count), .miss_count(miss_count),
        .overflow_flag(overflow_flag), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  typ;
        logic [7:0]  syn;
        logic        inj;
    } rec_t;

    rec_t        q[$];
    int unsigned m_ce, m_ue, m_ae, m_drop, m_miss;
    bit          m_ovf, m_irq, m_armed;
    longint      cyc, deadline;
    int          total = 0;
    int          bad = 0;

    logic [81:0] dut_vec;
    logic [43:0] dut_head;
    assign dut_vec  = {ce_count, ue_count, ae_count, drop_count, miss_count, overflow_flag, irq};
    assign dut_head = {intf.log_valid, intf.log_valid ?
                       {intf.log_addr, intf.log_type, intf.log_syndrome, intf.log_injected} : 43'b0};

    function automatic int unsigned sat(input int unsigned v);
        return (v >= CMAX) ? v : v + 1;
    endfunction

    function automatic logic [81:0] model_vec();
        return {16'(m_ce), 16'(m_ue), 16'(m_ae), 16'(m_drop), 16'(m_miss), m_ovf, m_irq};
    endfunction

    function automatic logic [43:0] model_head();
        if (q.size() == 0) return 44'b0;
        return {1'b1, q[0].addr, q[0].typ, q[0].syn, q[0].inj};
    endfunction

    task automatic model_clear();
        q.delete();
        m_ce = 0; m_ue = 0; m_ae = 0; m_drop = 0; m_miss = 0;
        m_ovf = 0; m_irq = 0; m_armed = 0;
    endtask

    // Applies the current inputs to the model, then advances the DUT one edge.
    task automatic tick();
        bit   acc, pop, inj, drop;
        rec_t r;
        cyc++;
        if (log_clear) begin
            model_clear();
        end else begin
            acc  = err_valid && (err_type != 2'b00);
            pop  = (q.size() != 0) && intf.log_ready;
            inj  = 0;
            drop = 0;
            if (m_armed) begin
                if (acc) begin
                    inj = 1;
                    m_armed = inject_pulse;
                end else if (inject_pulse || cyc == deadline) begin
                    m_miss = sat(m_miss);
                    m_armed = inject_pulse;
                end
            end else begin
                m_armed = inject_pulse;
            end
            if (inject_pulse) deadline = cyc + MW + 1;
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (q.size() < DEPTH) begin
                    r.addr = err_addr; r.typ = err_type; r.syn = err_syndrome; r.inj = inj;
                    q.push_back(r);
                end else begin
                    drop = 1;
                    m_drop = sat(m_drop);
                end
                case (err_type)
                    2'b01:   m_ce = sat(m_ce);
                    2'b10:   m_ue = sat(m_ue);
                    default: m_ae = sat(m_ae);
                endcase
            end
            if ((acc && err_type != 2'b01) || drop ||
                (acc && err_type == 2'b01 && irq_threshold != 0 && m_ce == irq_threshold))
                m_irq = 1;
            else if (irq_clear)
                m_irq = 0;
            if (drop) m_ovf = 1;
            else if (irq_clear) m_ovf = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_event(input bit v, input logic [1:0] t, input logic [31:0] a);
        err_valid = v; err_type = t; err_addr = a; err_syndrome = 8'($urandom);
    endtask

    task automatic do_clear();
        set_event(0, 2'b00, '0);
        log_clear = 1; tick(); log_clear = 0;
    endtask

    task automatic test_reset();
        total++;
        if ({dut_head, intf.log_addr, intf.log_syndrome} !== '0)
            $display("FAIL reset_log: got %h expected 0", {dut_head, intf.log_addr, intf.log_syndrome});
        total++;
        if (dut_vec !== '0) begin bad++; $display("FAIL reset_cnt: got %h expected 0", dut_vec); end
        if ({dut_head, intf.log_addr, intf.log_syndrome} !== '0) bad++;
    endtask

    task automatic test_in_order();
        logic [31:0] got[$];
        logic [31:0] want[3];
        want[0] = 32'h100; want[1] = 32'h104; want[2] = 32'h108;
        intf.log_ready = 1; irq_threshold = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) set_event(1, 2'b01, want[i]); else set_event(0, 2'b00, '0);
            tick();
            if (intf.log_valid) got.push_back(intf.log_addr);
        end
        total++;
        if (got.size() != 3) begin bad++; $display("FAIL order_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++;
            if (got[i] !== want[i]) begin bad++; $display("FAIL order_addr%0d: got %h expected %h", i, got[i], want[i]); end
        end
        total++;
        if ({ce_count, irq} !== {16'd3, 1'b0}) begin bad++; $display("FAIL order_ce_irq: got %h/%b expected 3/0", ce_count, irq); end
    endtask

    task automatic test_overflow();
        logic [31:0] first;
        do_clear();
        intf.log_ready = 0;
        first = $urandom;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_event(1, 2'b01, (i == 0) ? first : 32'($urandom));
            tick();
        end
        set_event(0, 2'b00, '0);
        total++;
        if ({drop_count, overflow_flag, irq, intf.log_valid} !== {16'd2, 3'b111}) begin
            bad++; $display("FAIL ovf_flags: got drop=%0d ovf=%b irq=%b valid=%b expected 2 1 1 1",
                            drop_count, overflow_flag, irq, intf.log_valid);
        end
        total++;
        if (intf.log_addr !== first) begin bad++; $display("FAIL ovf_head: got %h expected %h", intf.log_addr, first); end
        // Full FIFO pushing and popping together must not drop.
        intf.log_ready = 1;
        set_event(1, 2'b11, $urandom);
        tick();
        set_event(0, 2'b00, '0);
        total++;
        if (drop_count !== 16'd2) begin bad++; $display("FAIL full_push_pop: got drop=%0d expected 2", drop_count); end
        for (int i = 0; i < DEPTH + 1; i++) begin
            total++;
            if (dut_head !== model_head()) begin bad++; $display("FAIL ovf_drain: got %h expected %h", dut_head, model_head()); end
            tick();
        end
        total++;
        if (dut_vec !== model_vec()) begin bad++; $display("FAIL ovf_cnt: got %h expected %h", dut_vec, model_vec()); end
    endtask

    task automatic test_inject();
        do_clear();
        intf.log_ready = 0;
        inject_pulse = 1; tick(); inject_pulse = 0;
        for (int i = 0; i < 4; i++) tick();
        set_event(1, 2'b10, 32'h200); tick(); set_event(0, 2'b00, '0);
        total++;
        if ({intf.log_valid, intf.log_injected, ue_count, miss_count} !== {2'b11, 16'd1, 16'd0}) begin
            bad++; $display("FAIL inject_hit: got v=%b inj=%b ue=%0d miss=%0d expected 1 1 1 0",
                            intf.log_valid, intf.log_injected, ue_count, miss_count);
        end
        do_clear();
        inject_pulse = 1; tick(); inject_pulse = 0;
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (miss_count !== 16'd1) begin bad++; $display("FAIL inject_timeout: got %0d expected 1", miss_count); end
        do_clear();
        inject_pulse = 1; tick(); inject_pulse = 0;
        tick(); tick();
        inject_pulse = 1; tick(); inject_pulse = 0;
        tick();
        set_event(1, 2'b01, 32'h300); tick(); set_event(0, 2'b00, '0);
        for (int i = 0; i < 20; i++) tick();
        total++;
        if ({miss_count, intf.log_valid, intf.log_injected} !== {16'd1, 2'b11}) begin
            bad++; $display("FAIL inject_double: got miss=%0d v=%b inj=%b expected 1 1 1",
                            miss_count, intf.log_valid, intf.log_injected);
        end
        intf.log_ready = 1; tick(); tick();
    endtask

    task automatic test_threshold();
        do_clear();
        intf.log_ready = 1;
        irq_threshold = 4;
        for (int i = 0; i < 3; i++) begin set_event(1, 2'b01, $urandom); tick(); end
        set_event(0, 2'b00, '0); tick();
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL thr_below: got irq=%b expected 0", irq); end
        set_event(1, 2'b01, $urandom); tick(); set_event(0, 2'b00, '0);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL thr_hit: got irq=%b expected 1", irq); end
        irq_clear = 1; tick(); irq_clear = 0;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got irq=%b expected 0", irq); end
        irq_clear = 1; set_event(1, 2'b10, $urandom); tick();
        irq_clear = 0; set_event(0, 2'b00, '0);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins: got irq=%b expected 1", irq); end
        irq_threshold = 0;
    endtask

    task automatic test_random();
        do_clear();
        irq_threshold = 16'($urandom_range(0, 6));
        for (int i = 0; i < 1500; i++) begin
            intf.log_ready = ($urandom_range(0, 9) < 7);
            set_event($urandom_range(0, 1) == 1, 2'($urandom), $urandom);
            inject_pulse = ($urandom_range(0, 11) == 0);
            log_clear    = ($urandom_range(0, 199) == 0);
            irq_clear    = ($urandom_range(0, 29) == 0);
            tick();
            total++;
            if (dut_head !== model_head()) begin bad++; $display("FAIL rand_head@%0d: got %h expected %h", i, dut_head, model_head()); end
            total++;
            if (dut_vec !== model_vec()) begin bad++; $display("FAIL rand_cnt@%0d: got %h expected %h", i, dut_vec, model_vec()); end
        end
        set_event(0, 2'b00, '0);
        inject_pulse = 0; log_clear = 0; irq_clear = 0; irq_threshold = 0;
    endtask

    task automatic test_async_reset();
        intf.log_ready = 0;
        inject_pulse = 1;
        for (int i = 0; i < 4; i++) begin set_event(1, 2'($urandom_range(1, 3)), $urandom); tick(); inject_pulse = 0; end
        set_event(0, 2'b00, '0);
        #2 rst_n = 0;
        #1;
        model_clear();
        total++;
        if ({dut_head, dut_vec} !== '0) begin bad++; $display("FAIL async_reset: got %h expected 0", {dut_head, dut_vec}); end
        #1 rst_n = 1;
        intf.log_ready = 1;
        for (int i = 0; i < MW + 4; i++) tick();
        total++;
        if (dut_vec !== model_vec()) begin bad++; $display("FAIL post_reset: got %h expected %h", dut_vec, model_vec()); end
    endtask

    task automatic test_saturate();
        do_clear();
        intf.log_ready = 1;
        irq_threshold = 0;
        set_event(1, 2'b01, 32'h400);
        for (int i = 0; i < CMAX + 3; i++) tick();
        total++;
        if (ce_count !== 16'hFFFF || dut_vec !== model_vec()) begin
            bad++; $display("FAIL saturate: got ce=%h vec=%h expected ce=ffff vec=%h", ce_count, dut_vec, model_vec());
        end
        log_clear = 1; tick(); log_clear = 0;
        set_event(0, 2'b00, '0);
        total++;
        if ({dut_vec, intf.log_valid} !== '0) begin bad++; $display("FAIL clear_with_event: got %h expected 0", {dut_vec, intf.log_valid}); end
    endtask

    initial begin
        intf.log_ready = 0;
        model_clear();
        cyc = 0;
        deadline = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
        test_reset();
        test_in_order();
        test_overflow();
        test_inject();
        test_threshold();
        test_random();
        test_async_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
